// File: rtl/cmp_threshold_monitor_pkg.sv
// -----------------------------------------------------------------------------
// cmp_mon_pkg
// Shared types and constants for the threshold monitor:
//   region_e    - classification of a sample against the low/high window
//   cmp_evt_t   - event record {from, to, data} at the default sample width
//   CMP_LO_RST / CMP_HI_RST - threshold values loaded on reset
// -----------------------------------------------------------------------------
package cmp_mon_pkg;

   localparam int CMP_WIDTH = 4;

   typedef enum logic [1:0] {
      BELOW  = 2'b00,
      INSIDE = 2'b01,
      ABOVE  = 2'b10
   } region_e;

   typedef struct packed {
      region_e                from;
      region_e                to;
      logic [CMP_WIDTH-1:0]   data;
   } cmp_evt_t;

   localparam logic [CMP_WIDTH-1:0] CMP_LO_RST = 4'b0101;
   localparam logic [CMP_WIDTH-1:0] CMP_HI_RST = 4'b1010;

endpackage

// File: rtl/cmp_threshold_monitor_if.sv
// -----------------------------------------------------------------------------
// cmp_threshold_monitor_if
// Event stream from the monitor to the event consumer (valid/ready).
//   evt_valid  master->slave  event available
//   evt_ready  slave->master  consumer accepts event
//   evt_from   master->slave  region before the change
//   evt_to     master->slave  region after the change
//   evt_data   master->slave  sample that confirmed the change
// -----------------------------------------------------------------------------
interface cmp_threshold_monitor_if
   import cmp_mon_pkg::*;
#(
   parameter int WIDTH = 4
);

   logic              evt_valid;
   logic              evt_ready;
   region_e           evt_from;
   region_e           evt_to;
   logic [WIDTH-1:0]  evt_data;

   modport master (
      output evt_valid, evt_from, evt_to, evt_data,
      input  evt_ready
   );

   modport slave (
      input  evt_valid, evt_from, evt_to, evt_data,
      output evt_ready
   );

endinterface

// File: rtl/cmp_threshold_monitor_evt_fifo.sv
// -----------------------------------------------------------------------------
// cmp_mon_evt_fifo
// Two-entry synchronous FIFO of event records, in-order output.
//   clk, rst  clock, synchronous active-high reset
//   push_i    write data_i (accepted when not full, or when full and popping)
//   data_i    record to write
//   pop_i     remove head (ignored when empty)
//   data_o    head record; stable until popped
//   empty_o   no record held
//   drop_o    push refused because full with no pop this cycle
// -----------------------------------------------------------------------------
module cmp_mon_evt_fifo
   import cmp_mon_pkg::*;
#(
   parameter type T = cmp_evt_t
)(
   input  logic clk,
   input  logic rst,
   input  logic push_i,
   input  T     data_i,
   input  logic pop_i,
   output T     data_o,
   output logic empty_o,
   output logic drop_o
);

   T           mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] cnt_q;

   logic full;
   logic do_pop;
   logic do_push;

   assign full    = (cnt_q == 2'd2);
   assign empty_o = (cnt_q == 2'd0);
   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot being written, so a full FIFO can still accept.
   assign do_push = push_i && (!full || do_pop);
   assign drop_o  = push_i && full && !do_pop;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the storage is reset as well, because the head record drives the
         // event payload outputs directly and those must read zero after reset.
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) rd_ptr_q <= ~rd_ptr_q;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/cmp_threshold_monitor.sv
// -----------------------------------------------------------------------------
// cmp_threshold_monitor
// Classifies each accepted sample as BELOW / INSIDE / ABOVE a programmable
// window, confirms a region change after PERSIST consecutive samples in the
// same new region, and queues one event record per confirmed change.
//   clk, rst          clock, synchronous active-high reset
//   in_valid_i        sample present
//   in_ready_o        always 1; every sample is accepted
//   in_data_i         unsigned sample
//   cfg_we_i          load thresholds
//   cfg_lo_i/hi_i     new thresholds; rejected when lo > hi
//   cfg_err_o         one-cycle pulse after a rejected load
//   region_o          current confirmed region
//   overflow_o        sticky; an event was dropped (full buffer)
//   evt_if            event stream (master side)
//   evt_count_o       confirmed-change count, saturating (only with
//                     CMP_MON_EVT_COUNT_EN defined)
// -----------------------------------------------------------------------------
module cmp_threshold_monitor
   import cmp_mon_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int PERSIST = 3
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [WIDTH-1:0]      in_data_i,
   input  logic                  cfg_we_i,
   input  logic [WIDTH-1:0]      cfg_lo_i,
   input  logic [WIDTH-1:0]      cfg_hi_i,
   output logic                  cfg_err_o,
   output region_e               region_o,
   output logic                  overflow_o,
`ifdef CMP_MON_EVT_COUNT_EN
   output logic [7:0]            evt_count_o,
`endif
   cmp_threshold_monitor_if.master evt_if
);

   typedef struct packed {
      region_e          from;
      region_e          to;
      logic [WIDTH-1:0] data;
   } evt_t;

   logic [WIDTH-1:0] lo_q, hi_q;
   region_e          region_q, cand_q, samp_r;
   logic [3:0]       cnt_q, cnt_upd;
   logic             cfg_err_q, overflow_q;
   logic             cfg_ok, confirm, pop, empty, drop;
   evt_t             evt_in, evt_head;

   assign in_ready_o = 1'b1;
   assign cfg_ok     = (cfg_lo_i <= cfg_hi_i);

   always_comb begin
      samp_r = INSIDE;
      if (in_data_i > hi_q)      samp_r = ABOVE;
      else if (in_data_i < lo_q) samp_r = BELOW;
   end

   // Count the filter would hold after this sample, assuming it is out of region.
   always_comb begin
      cnt_upd = 4'd1;
      if (samp_r == cand_q) cnt_upd = cnt_q + 4'd1;
   end

   assign confirm = in_valid_i && (samp_r != region_q) && (cnt_upd == 4'(PERSIST));

   // Persistence filter; region_q is the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         lo_q       <= WIDTH'(CMP_LO_RST);
         hi_q       <= WIDTH'(CMP_HI_RST);
         region_q   <= INSIDE;
         cand_q     <= INSIDE;
         cnt_q      <= '0;
         cfg_err_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         // NOTE: every register here uses non-blocking assignment, so all
         // decisions in this block see the pre-edge thresholds and counter.
         cfg_err_q  <= cfg_we_i && !cfg_ok;
         overflow_q <= overflow_q | drop;
         if (in_valid_i) begin
            if (samp_r == region_q) begin
               cnt_q <= '0;
            end else if (confirm) begin
               region_q <= samp_r;
               cand_q   <= samp_r;
               cnt_q    <= '0;
            end else begin
               cand_q <= samp_r;
               cnt_q  <= cnt_upd;
            end
         end
         // Placed after the sample update so a load in the same cycle wins on cnt_q.
         if (cfg_we_i && cfg_ok) begin
            lo_q  <= cfg_lo_i;
            hi_q  <= cfg_hi_i;
            cnt_q <= '0;
         end
      end
   end

`ifdef CMP_MON_EVT_COUNT_EN
   logic [7:0] evt_count_q;

   always_ff @(posedge clk) begin
      if (rst)                                evt_count_q <= '0;
      else if (confirm && evt_count_q != 8'hFF) evt_count_q <= evt_count_q + 8'd1;
   end

   assign evt_count_o = evt_count_q;
`endif

   assign evt_in = '{from: region_q, to: samp_r, data: in_data_i};
   assign pop    = evt_if.evt_valid && evt_if.evt_ready;

   cmp_mon_evt_fifo #(.T(evt_t)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (confirm),
      .data_i  (evt_in),
      .pop_i   (pop),
      .data_o  (evt_head),
      .empty_o (empty),
      .drop_o  (drop)
   );

   assign evt_if.evt_valid = !empty;
   assign evt_if.evt_from  = evt_head.from;
   assign evt_if.evt_to    = evt_head.to;
   assign evt_if.evt_data  = evt_head.data;

   assign cfg_err_o  = cfg_err_q;
   assign region_o   = region_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// -----------------------------------------------------------------------------
// tb_cmp_threshold_monitor
// Directed bench for cmp_threshold_monitor: a PERSIST=3 instance for the main
// scenarios and a PERSIST=1 instance for the inclusive-bound case.
// Region codes: BELOW=0, INSIDE=1, ABOVE=2.
// -----------------------------------------------------------------------------
module tb_cmp_threshold_monitor;
   import cmp_mon_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, cfg_we, cfg_err, in_ready, overflow;
   logic [3:0] in_data, cfg_lo, cfg_hi;
   region_e    region;
   logic       v1, in_ready1, cfg_err1, overflow1;
   logic [3:0] d1;
   region_e    region1;
`ifdef CMP_MON_EVT_COUNT_EN
   logic [7:0] evt_count, evt_count1;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cmp_threshold_monitor_if #(.WIDTH(4)) evt_if0 ();
   cmp_threshold_monitor_if #(.WIDTH(4)) evt_if1 ();

   cmp_threshold_monitor #(.WIDTH(4), .PERSIST(3)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .cfg_we_i    (cfg_we),
      .cfg_lo_i    (cfg_lo),
      .cfg_hi_i    (cfg_hi),
      .cfg_err_o   (cfg_err),
      .region_o    (region),
      .overflow_o  (overflow),
`ifdef CMP_MON_EVT_COUNT_EN
      .evt_count_o (evt_count),
`endif
      .evt_if      (evt_if0)
   );

   cmp_threshold_monitor #(.WIDTH(4), .PERSIST(1)) u_dut1 (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (v1),
      .in_ready_o  (in_ready1),
      .in_data_i   (d1),
      .cfg_we_i    (1'b0),
      .cfg_lo_i    (4'd0),
      .cfg_hi_i    (4'd15),
      .cfg_err_o   (cfg_err1),
      .region_o    (region1),
      .overflow_o  (overflow1),
`ifdef CMP_MON_EVT_COUNT_EN
      .evt_count_o (evt_count1),
`endif
      .evt_if      (evt_if1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [3:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run(input logic [3:0] d, input int n);
      for (int i = 0; i < n; i++) sample(d);
   endtask

   task automatic check_evt(input string tag, input logic [1:0] f, input logic [1:0] t,
                            input logic [3:0] d);
      check({tag, "_valid"}, evt_if0.evt_valid, 1);
      check({tag, "_from"},  evt_if0.evt_from,  f);
      check({tag, "_to"},    evt_if0.evt_to,    t);
      check({tag, "_data"},  evt_if0.evt_data,  d);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0; cfg_lo = '0; cfg_hi = '0;
      v1 = 1'b0; d1 = '0;
      evt_if0.evt_ready = 1'b1;
      evt_if1.evt_ready = 1'b1;
      tick();
      check("in_ready_in_rst", in_ready, 1);
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_region",   region,            1);
      check("rst_valid",    evt_if0.evt_valid, 0);
      check("rst_from",     evt_if0.evt_from,  0);
      check("rst_to",       evt_if0.evt_to,    0);
      check("rst_data",     evt_if0.evt_data,  0);
      check("rst_overflow", overflow,          0);
      check("rst_cfg_err",  cfg_err,           0);

      // Samples inside the window: nothing happens
      run(7, 3);
      check("in7_region", region, 1);
      check("in7_valid",  evt_if0.evt_valid, 0);

      // INSIDE -> ABOVE after third 11
      run(11, 2);
      check("a11_2_region", region, 1);
      sample(11);
      check("a11_3_region", region, 2);
      check_evt("a11_evt", 1, 2, 11);
      tick();
      check("a11_popped", evt_if0.evt_valid, 0);
      run(7, 3);
      tick();
      check("back_in_region", region, 1);

      // Candidate restarts when the out-of-region direction changes
      run(11, 2);
      run(3, 2);
      check("restart_region", region, 1);
      check("restart_valid",  evt_if0.evt_valid, 0);
      sample(3);
      check("b3_region", region, 0);
      check_evt("b3_evt", 1, 0, 3);
      tick();
      run(7, 3);
      tick();
      check("back_in2_region", region, 1);

      // Consumer stalled: two held, third dropped
      evt_if0.evt_ready = 1'b0;
      run(11, 3);
      check_evt("ov_first", 1, 2, 11);
      run(3, 3);
      check_evt("ov_hold", 1, 2, 11);
      check("ov_not_yet", overflow, 0);
      run(7, 3);
      check("ov_set",    overflow, 1);
      check("ov_region", region,   1);
      check_evt("ov_head", 1, 2, 11);
`ifdef CMP_MON_EVT_COUNT_EN
      check("evt_count_7", evt_count, 7);
`endif
      evt_if0.evt_ready = 1'b1;
      tick();
      check_evt("ov_second", 2, 0, 3);
      tick();
      check("ov_drained", evt_if0.evt_valid, 0);
      check("ov_sticky",  overflow, 1);

      // Rejected load: lo > hi
      cfg_we = 1'b1; cfg_lo = 12; cfg_hi = 4;
      tick();
      cfg_we = 1'b0;
      check("cfg_err_pulse", cfg_err, 1);
      tick();
      check("cfg_err_clear", cfg_err, 0);
      run(10, 3);
      run(5, 3);
      check("keep_thr_region", region, 1);
      check("keep_thr_valid",  evt_if0.evt_valid, 0);

      // Valid load clears the persistence counter
      run(11, 2);
      cfg_we = 1'b1; cfg_lo = 5; cfg_hi = 10;
      tick();
      cfg_we = 1'b0;
      check("cfg_ok_no_err", cfg_err, 0);
      run(11, 2);
      check("cnt_cleared_region", region, 1);
      sample(11);
      check("cnt_cleared_change", region, 2);
      tick();
      run(7, 3);
      tick();

      // Full-range window: extremes are INSIDE
      cfg_we = 1'b1; cfg_lo = 0; cfg_hi = 15;
      tick();
      cfg_we = 1'b0;
      run(15, 3);
      run(0, 3);
      check("wide_region", region, 1);
      check("wide_valid",  evt_if0.evt_valid, 0);

      // Load with a sample in the same cycle: sample uses the old window
      cfg_we = 1'b1; cfg_lo = 5; cfg_hi = 10;
      sample(11);
      cfg_we = 1'b0;
      run(11, 2);
      check("same_cycle_region", region, 1);
      sample(11);
      check("same_cycle_change", region, 2);
      check_evt("same_cycle_evt", 1, 2, 11);
      tick();

      // PERSIST=1: hi bound is inclusive, one sample above confirms
      v1 = 1'b1; d1 = 10;
      tick();
      check("p1_10_region", region1, 1);
      check("p1_10_valid",  evt_if1.evt_valid, 0);
      d1 = 11;
      tick();
      v1 = 1'b0;
      check("p1_11_region", region1, 2);
      check("p1_11_valid",  evt_if1.evt_valid, 1);
      check("p1_11_from",   evt_if1.evt_from, 1);
      check("p1_11_to",     evt_if1.evt_to, 2);
      check("p1_11_data",   evt_if1.evt_data, 11);
`ifdef CMP_MON_EVT_COUNT_EN
      check("p1_evt_count", evt_count1, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
